frame_buf_ptr_sched: RTL and testbench
======================================

// Module: frame_buf_ptr_sched
// PURPOSE
//  Frame-buffer slot scheduler for the video-in capture path: owns the ring of NUM_FRAMES DDR frame slots.
//  Issues the slot index the capture writer fills (wr_ptr_o -> d_frame_wr_ptr_i of the capture address
//  generator) and the slot the consumer (display/scaler reader) reads, so neither touches a slot in use.
//  Drops/repeats frames when producer and consumer rates differ. Triple+ buffering, newest-frame policy.
// PARAMETERS
//  NUM_FRAMES  4  slots in ring; legal 3..8 (fits 3-bit slot field of the DDR frame address)
//  CNT_W      16  width of statistics counters
// PORTS
//  vid_in_clk_i        in   1      sole clock
//  resetn_i            in   1      synchronous reset, active low
//  wr_frame_done_i     in   1      1-cycle pulse: writer finished slot wr_ptr_o
//  rd_frame_start_i    in   1      1-cycle pulse: consumer begins a frame; samples rd_ptr_o next cycle
//  freeze_i            in   1      level: hold rd_ptr_o (pause image); writer keeps cycling
//  wr_ptr_o            out  3      slot writer fills
//  rd_ptr_o            out  3      slot consumer reads
//  rd_ptr_valid_o      out  1      at least one complete frame exists
//  drop_cnt_o          out  CNT_W  frames overwritten unread (stats build only)
//  repeat_cnt_o        out  CNT_W  frame starts with no new frame (stats build only)
// BEHAVIOUR
//  - All outputs registered; update the cycle after the triggering pulse (1-cycle latency).
//  - Reset (resetn_i low at clk edge): wr_ptr_o=0, rd_ptr_o=NUM_FRAMES-1, rd_ptr_valid_o=0, counters=0,
//    ready_ptr=0, new_avail=0, state=S_EMPTY. Reset mid-frame abandons all slot contents.
//  - States: S_EMPTY (no complete frame) -> S_RUN on first wr_frame_done_i. S_RUN left only by reset.
//  - On wr_frame_done_i: ready_ptr<=wr_ptr_o; if new_avail already 1 then drop_cnt++; new_avail<=1;
//    wr_ptr_o<=first slot scanning upward (mod NUM_FRAMES) from wr_ptr_o+1 that != next rd_ptr_o and
//    != old wr_ptr_o. NUM_FRAMES>=3 guarantees a slot exists.
//  - On rd_frame_start_i in S_RUN, freeze_i=0: if new_avail, rd_ptr_o<=ready_ptr, new_avail<=0;
//    else rd_ptr_o unchanged, repeat_cnt++. In S_EMPTY: no change, repeat_cnt++.
//  - freeze_i=1: rd_frame_start_i leaves rd_ptr_o and new_avail unchanged, no counting; writer skips rd slot.
//  - Simultaneous wr_frame_done_i & rd_frame_start_i: reader takes the slot completing this cycle
//    (old wr_ptr_o) unless frozen; next wr slot excludes that new rd_ptr_o; no drop counted.
//  - rd_ptr_valid_o=1 from cycle after first wr_frame_done_i (state==S_RUN).
//  - Ring wrap: index NUM_FRAMES-1 -> 0. Counters saturate at all-ones, never wrap.
// CONFIGURATION
//  FRAME_PTR_STATS_EN defined: drop_cnt_o/repeat_cnt_o counters built as above.
//  Not defined: counters not built, drop_cnt_o/repeat_cnt_o tied to 0; pointer behaviour identical.
// STRUCTURE
//  Package frame_buf_pkg: FRAME_PTR_W=3, MAX_FRAMES=8, typedef logic [2:0] frame_ptr_t,
//    enum {S_EMPTY,S_RUN} sched_state_e.
//  Sub-module frame_slot_pick: combinational next-slot search (start, excl_a, excl_b, NUM_FRAMES) -> slot.
// TESTING
//  1 Reset, NUM_FRAMES=4 -> wr=0 rd=3 valid=0; rd_start in S_EMPTY -> rd stays 3, repeat=1.
//  2 done at wr=0 -> valid=1, wr=1; rd_start -> rd=0; done x2 -> wr 2 then 3 (skips none), drop=1.
//  3 rd=2, wr=1, done -> wr=3 (skips rd 2); next done -> wr=0; wrap verified.
//  4 done and rd_start same cycle at wr=1, rd=0 -> rd=1, wr=2, drop unchanged.
//  5 freeze_i=1, rd=1, 5 done pulses + rd_starts -> rd stays 1, wr never 1; release -> rd=newest.
//  6 NUM_FRAMES=3, 0xFFFF+2 rd_starts w/o new frame -> repeat_cnt_o=0xFFFF (saturated); no stats build -> 0.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the video-in frame-buffer slot scheduler.
// Slot indices are 3 bits wide so the ring can be sized up to 8 frames.
package frame_buf_pkg;

   localparam int FRAME_PTR_W = 3;
   localparam int MAX_FRAMES  = 8;

   typedef logic [FRAME_PTR_W-1:0] frame_ptr_t;

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_RUN   = 1'b1
   } sched_state_e;

   // Ring addition for small steps: both operands are below num, so the
   // sum never reaches 2*num and a single conditional subtract wraps it.
   function automatic frame_ptr_t ptr_add(input frame_ptr_t base,
                                          input frame_ptr_t step,
                                          input logic [3:0]  num);
      logic [3:0] sum_v;
      sum_v = {1'b0, base} + {1'b0, step};
      if (sum_v >= num) begin
         sum_v = sum_v - num;
      end else begin
         sum_v = sum_v;
      end
      return sum_v[FRAME_PTR_W-1:0];
   endfunction

endpackage

// File: rtl/frame_slot_pick.sv
// Combinational next-slot search: first slot at or above 'start' (mod
// NUM_FRAMES) that is neither excl_a nor excl_b. With at most two slots
// excluded and NUM_FRAMES >= 3, one of the first three candidates always wins.
module frame_slot_pick
   import frame_buf_pkg::*;
#(
   parameter int NUM_FRAMES = 4
) (
   input  frame_ptr_t start,
   input  frame_ptr_t excl_a,
   input  frame_ptr_t excl_b,
   output frame_ptr_t slot
);

   localparam logic [3:0] NUM_L = 4'(NUM_FRAMES);

   frame_ptr_t cand_s;
   logic       found_s;

   // Scan three candidates upward from start and keep the first free one.
   always_comb begin
      slot    = start;
      found_s = 1'b0;
      cand_s  = start;
      for (int i = 0; i < 3; i++) begin
         cand_s = ptr_add(start, 3'(i), NUM_L);
         if (!found_s && (cand_s != excl_a) && (cand_s != excl_b)) begin
            slot    = cand_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/frame_buf_ptr_sched.sv
// Frame-buffer slot scheduler for the video-in capture path.
// Owns the ring of NUM_FRAMES DDR frame slots, hands the writer a slot the
// reader is not using and hands the reader the newest completed frame.
// Optional statistics counters are built when FRAME_PTR_STATS_EN is defined;
// otherwise drop_cnt_o/repeat_cnt_o are tied to zero.
module frame_buf_ptr_sched
   import frame_buf_pkg::*;
#(
   parameter int NUM_FRAMES = 4,
   parameter int CNT_W      = 16
) (
   input  logic             vid_in_clk_i,
   input  logic             resetn_i,
   input  logic             wr_frame_done_i,
   input  logic             rd_frame_start_i,
   input  logic             freeze_i,
   output logic [2:0]       wr_ptr_o,
   output logic [2:0]       rd_ptr_o,
   output logic             rd_ptr_valid_o,
   output logic [CNT_W-1:0] drop_cnt_o,
   output logic [CNT_W-1:0] repeat_cnt_o
);

   localparam logic [3:0] NUM_L  = 4'(NUM_FRAMES);
   localparam frame_ptr_t RD_RST = 3'(NUM_FRAMES - 1);

   sched_state_e state_r;
   sched_state_e state_nxt_s;
   frame_ptr_t   wr_ptr_r;
   frame_ptr_t   wr_nxt_s;
   frame_ptr_t   rd_ptr_r;
   frame_ptr_t   rd_nxt_s;
   frame_ptr_t   ready_ptr_r;
   frame_ptr_t   ready_nxt_s;
   logic         new_avail_r;
   logic         new_nxt_s;
   logic         valid_r;
   logic         rd_go_s;
   logic         rd_take_ready_s;
   logic         drop_evt_s;
   logic         repeat_evt_s;
   frame_ptr_t   wr_start_s;
   frame_ptr_t   wr_pick_s;

   // A frozen reader ignores frame starts entirely.
   assign rd_go_s    = rd_frame_start_i & ~freeze_i;
   assign wr_start_s = ptr_add(wr_ptr_r, 3'd1, NUM_L);

   // Next writer slot must avoid the slot the reader will hold next cycle
   // and the slot that was just completed.
   frame_slot_pick #(
      .NUM_FRAMES (NUM_FRAMES)
   ) u_slot_pick (
      .start  (wr_start_s),
      .excl_a (rd_nxt_s),
      .excl_b (wr_ptr_r),
      .slot   (wr_pick_s)
   );

   // Reader side: pick the slot for the next frame start or count a repeat.
   always_comb begin
      rd_nxt_s        = rd_ptr_r;
      rd_take_ready_s = 1'b0;
      repeat_evt_s    = 1'b0;
      if (rd_go_s) begin
         if (wr_frame_done_i) begin
            // Frame completing this very cycle is the newest one.
            rd_nxt_s = wr_ptr_r;
         end else if ((state_r == S_RUN) && new_avail_r) begin
            rd_nxt_s        = ready_ptr_r;
            rd_take_ready_s = 1'b1;
         end else begin
            repeat_evt_s = 1'b1;
         end
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
   end

   // Writer side and state machine: publish completed frames, advance writer.
   always_comb begin
      state_nxt_s = state_r;
      wr_nxt_s    = wr_ptr_r;
      ready_nxt_s = ready_ptr_r;
      new_nxt_s   = new_avail_r;
      drop_evt_s  = 1'b0;

      case (state_r)
         S_EMPTY: begin
            if (wr_frame_done_i) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_EMPTY;
            end
         end
         S_RUN: begin
            state_nxt_s = S_RUN;
         end
         default: begin
            state_nxt_s = S_EMPTY;
         end
      endcase

      if (wr_frame_done_i) begin
         ready_nxt_s = wr_ptr_r;
         wr_nxt_s    = wr_pick_s;
         // A reader starting this cycle consumes the frame immediately.
         new_nxt_s   = ~rd_go_s;
         drop_evt_s  = new_avail_r & ~rd_go_s;
      end else if (rd_take_ready_s) begin
         new_nxt_s = 1'b0;
      end else begin
         new_nxt_s = new_avail_r;
      end
   end

   // Scheduler state registers with synchronous active-low reset.
   always_ff @(posedge vid_in_clk_i) begin
      if (!resetn_i) begin
         state_r     <= S_EMPTY;
         wr_ptr_r    <= 3'd0;
         rd_ptr_r    <= RD_RST;
         ready_ptr_r <= 3'd0;
         new_avail_r <= 1'b0;
         valid_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         wr_ptr_r    <= wr_nxt_s;
         rd_ptr_r    <= rd_nxt_s;
         ready_ptr_r <= ready_nxt_s;
         new_avail_r <= new_nxt_s;
         valid_r     <= (state_nxt_s == S_RUN);
      end
   end

   assign wr_ptr_o       = wr_ptr_r;
   assign rd_ptr_o       = rd_ptr_r;
   assign rd_ptr_valid_o = valid_r;

`ifdef FRAME_PTR_STATS_EN
   logic [CNT_W-1:0] drop_cnt_r;
   logic [CNT_W-1:0] repeat_cnt_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      if (&val) begin
         return val;
      end else begin
         return val + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Saturating statistics counters for dropped and repeated frames.
   always_ff @(posedge vid_in_clk_i) begin
      if (!resetn_i) begin
         drop_cnt_r   <= {CNT_W{1'b0}};
         repeat_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (drop_evt_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
         if (repeat_evt_s) begin
            repeat_cnt_r <= sat_inc(repeat_cnt_r);
         end else begin
            repeat_cnt_r <= repeat_cnt_r;
         end
      end
   end

   assign drop_cnt_o   = drop_cnt_r;
   assign repeat_cnt_o = repeat_cnt_r;
`else
   logic stats_unused_s;
   assign stats_unused_s = drop_evt_s ^ repeat_evt_s;
   assign drop_cnt_o     = {CNT_W{1'b0}};
   assign repeat_cnt_o   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_frame_buf_ptr_sched.sv
// Self-checking bench for frame_buf_ptr_sched (NUM_FRAMES=4 main instance,
// NUM_FRAMES=3 instance for counter saturation).
module tb_frame_buf_ptr_sched;

   logic        clk = 1'b0;
   logic        resetn, done, start, frz;
   logic [2:0]  wr, rd;
   logic        valid;
   logic [15:0] drop_cnt, rep_cnt;

   logic        resetn3, done3, start3, frz3;
   logic [2:0]  wr3, rd3;
   logic        valid3;
   logic [15:0] drop3, rep3;

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model state (NUM_FRAMES = 4)
   localparam int MN = 4;
   int m_wr, m_rd, m_ready, m_drop, m_rep;
   bit m_new, m_run;

   always #5 clk = ~clk;

   frame_buf_ptr_sched #(.NUM_FRAMES(4), .CNT_W(16)) dut (
      .vid_in_clk_i(clk), .resetn_i(resetn), .wr_frame_done_i(done),
      .rd_frame_start_i(start), .freeze_i(frz), .wr_ptr_o(wr), .rd_ptr_o(rd),
      .rd_ptr_valid_o(valid), .drop_cnt_o(drop_cnt), .repeat_cnt_o(rep_cnt));

   frame_buf_ptr_sched #(.NUM_FRAMES(3), .CNT_W(16)) dut3 (
      .vid_in_clk_i(clk), .resetn_i(resetn3), .wr_frame_done_i(done3),
      .rd_frame_start_i(start3), .freeze_i(frz3), .wr_ptr_o(wr3), .rd_ptr_o(rd3),
      .rd_ptr_valid_o(valid3), .drop_cnt_o(drop3), .repeat_cnt_o(rep3));

   // expected statistics value depending on build
   function automatic logic [15:0] exp_cnt(input int v);
`ifdef FRAME_PTR_STATS_EN
      return (v > 65535) ? 16'hFFFF : 16'(v);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      m_wr = 0; m_rd = MN - 1; m_ready = 0; m_new = 0; m_run = 0;
      m_drop = 0; m_rep = 0;
   endtask

   // Spec-level update: reader choice first, then writer moves to the nearest
   // slot ahead of itself that the reader does not hold.
   task automatic model_update(input bit d, input bit s, input bit f);
      bit go;
      int nrd;
      bit nnew;
      go = s && !f;
      nrd = m_rd;
      nnew = m_new;
      if (go) begin
         if (d) nrd = m_wr;
         else if (m_run && m_new) begin nrd = m_ready; nnew = 0; end
         else m_rep = (m_rep < 65535) ? m_rep + 1 : 65535;
      end
      if (d) begin
         if (m_new && !go) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
         m_ready = m_wr;
         nnew = !go;
         m_run = 1;
         for (int k = 1; k < MN; k++) begin
            if (((m_wr + k) % MN) != nrd) begin
               m_wr = (m_wr + k) % MN;
               break;
            end
         end
      end
      m_rd = nrd;
      m_new = nnew;
   endtask

   task automatic step(input bit d, input bit s, input bit f);
      done = d; start = s; frz = f;
      @(posedge clk);
      model_update(d, s, f);
      #1;
      done = 1'b0; start = 1'b0; frz = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0; done = 1'b0; start = 1'b0; frz = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({wr, rd, valid} !== {3'd0, 3'd3, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_ptrs: got wr=%0d rd=%0d valid=%0b, want wr=0 rd=3 valid=0", wr, rd, valid);
      end
      tests_run++;
      if ({drop_cnt, rep_cnt} !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_cnts: got drop=%0d rep=%0d, want 0 0", drop_cnt, rep_cnt);
      end
      step(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (rd !== 3'd3 || valid !== 1'b0 || rep_cnt !== exp_cnt(1)) begin
         tests_failed++;
         $display("FAIL empty_start: got rd=%0d valid=%0b rep=%0d, want rd=3 valid=0 rep=%0d",
                  rd, valid, rep_cnt, exp_cnt(1));
      end
   endtask

   task automatic test_basic();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (wr !== 3'd1 || valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_done: got wr=%0d valid=%0b, want wr=1 valid=1", wr, valid);
      end
      step(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (rd !== 3'd0) begin
         tests_failed++;
         $display("FAIL first_read: got rd=%0d, want 0", rd);
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (wr !== 3'd3 || drop_cnt !== exp_cnt(1)) begin
         tests_failed++;
         $display("FAIL double_done: got wr=%0d drop=%0d, want wr=3 drop=%0d", wr, drop_cnt, exp_cnt(1));
      end
   endtask

   // continues from test_basic's final state (wr=3 rd=0 one frame pending)
   task automatic test_wrap();
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (rd !== 3'd2 || wr !== 3'd1) begin
         tests_failed++;
         $display("FAIL wrap_setup: got rd=%0d wr=%0d, want rd=2 wr=1", rd, wr);
      end
      step(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (wr !== 3'd3) begin
         tests_failed++;
         $display("FAIL skip_rd: got wr=%0d, want 3", wr);
      end
      step(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (wr !== 3'd0 || drop_cnt !== exp_cnt(m_drop)) begin
         tests_failed++;
         $display("FAIL ring_wrap: got wr=%0d drop=%0d, want wr=0 drop=%0d", wr, drop_cnt, exp_cnt(m_drop));
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] drop_before;
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      drop_before = exp_cnt(m_drop);
      step(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (rd !== 3'd1 || wr !== 3'd2 || drop_cnt !== drop_before) begin
         tests_failed++;
         $display("FAIL simultaneous: got rd=%0d wr=%0d drop=%0d, want rd=1 wr=2 drop=%0d",
                  rd, wr, drop_cnt, drop_before);
      end
   endtask

   task automatic test_freeze();
      int bad;
      logic [15:0] rep_before;
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      rep_before = exp_cnt(m_rep);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1);
         if (rd !== 3'd1 || wr === 3'd1) bad++;
         step(1'b0, 1'b1, 1'b1);
         if (rd !== 3'd1) bad++;
      end
      tests_run++;
      if (bad != 0 || rep_cnt !== rep_before) begin
         tests_failed++;
         $display("FAIL freeze_hold: %0d bad cycles, rd=%0d rep=%0d, want rd=1 wr!=1 rep=%0d",
                  bad, rd, rep_cnt, rep_before);
      end
      step(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (rd !== 3'd3) begin
         tests_failed++;
         $display("FAIL freeze_release: got rd=%0d, want newest 3", rd);
      end
   endtask

   task automatic test_random();
      bit d, s, f;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         d = ($urandom_range(0, 2) == 0);
         s = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 4) == 0);
         step(d, s, f);
         tests_run++;
         if ({wr, rd, valid} !== {3'(m_wr), 3'(m_rd), m_run} ||
             drop_cnt !== exp_cnt(m_drop) || rep_cnt !== exp_cnt(m_rep)) begin
            tests_failed++;
            $display("FAIL random[%0d]: got wr=%0d rd=%0d v=%0b drop=%0d rep=%0d, want wr=%0d rd=%0d v=%0b drop=%0d rep=%0d",
                     i, wr, rd, valid, drop_cnt, rep_cnt, m_wr, m_rd, m_run,
                     exp_cnt(m_drop), exp_cnt(m_rep));
         end
      end
   endtask

   task automatic test_saturate();
      resetn3 = 1'b0; done3 = 1'b0; start3 = 1'b0; frz3 = 1'b0;
      @(posedge clk);
      #1;
      resetn3 = 1'b1;
      tests_run++;
      if ({wr3, rd3, valid3} !== {3'd0, 3'd2, 1'b0}) begin
         tests_failed++;
         $display("FAIL n3_reset: got wr=%0d rd=%0d valid=%0b, want 0 2 0", wr3, rd3, valid3);
      end
      start3 = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      tests_run++;
      if (rep3 !== exp_cnt(65535)) begin
         tests_failed++;
         $display("FAIL n3_rep_full: got rep=%0d, want %0d", rep3, exp_cnt(65535));
      end
      repeat (2) @(posedge clk);
      #1;
      start3 = 1'b0;
      tests_run++;
      if (rep3 !== exp_cnt(65537) || rd3 !== 3'd2 || drop3 !== 16'h0) begin
         tests_failed++;
         $display("FAIL n3_rep_sat: got rep=%0d rd=%0d drop=%0d, want rep=%0d rd=2 drop=0",
                  rep3, rd3, drop3, exp_cnt(65537));
      end
   endtask

   initial begin
      resetn = 1'b0; done = 1'b0; start = 1'b0; frz = 1'b0;
      resetn3 = 1'b0; done3 = 1'b0; start3 = 1'b0; frz3 = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_freeze();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
